// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan decoder:
//   - SEG7_0..SEG7_9 : segment patterns {a,b,c,d,e,f,g}, a = bit 6, active-high
//   - DSEL_D3..DSEL_D0, DSEL_BLANK : one-hot digit-select codes
//   - state_t        : frame assembly state
//   - expected_sel() : digit select the FSM is waiting for in a given state
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam logic [6:0] SEG7_0 = 7'b1111110;
    localparam logic [6:0] SEG7_1 = 7'b0110000;
    localparam logic [6:0] SEG7_2 = 7'b1101101;
    localparam logic [6:0] SEG7_3 = 7'b1111001;
    localparam logic [6:0] SEG7_4 = 7'b0110011;
    localparam logic [6:0] SEG7_5 = 7'b1011011;
    localparam logic [6:0] SEG7_6 = 7'b1011111;
    localparam logic [6:0] SEG7_7 = 7'b1110000;
    localparam logic [6:0] SEG7_8 = 7'b1111111;
    localparam logic [6:0] SEG7_9 = 7'b1111011;

    localparam logic [3:0] DSEL_D3    = 4'b1000;
    localparam logic [3:0] DSEL_D2    = 4'b0100;
    localparam logic [3:0] DSEL_D1    = 4'b0010;
    localparam logic [3:0] DSEL_D0    = 4'b0001;
    localparam logic [3:0] DSEL_BLANK = 4'b0000;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        EXP_D2 = 2'd1,
        EXP_D1 = 2'd2,
        EXP_D0 = 2'd3
    } state_t;

    function automatic logic [3:0] expected_sel(input state_t s);
        case (s)
            EXP_D2:  return DSEL_D2;
            EXP_D1:  return DSEL_D1;
            EXP_D0:  return DSEL_D0;
            default: return DSEL_D3;
        endcase
    endfunction

endpackage

// File: rtl/seg7_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder_if
// Bundle between a scanning display driver (master) and the scan decoder
// (slave).
//   dig_sel     : one-hot digit select, 4'b1000 = D3 (leftmost), 0 = blank
//   seg_in      : segment lines {a..g}, active-high
//   digits      : last good frame {D3,D2,D1,D0} as BCD nibbles
//   frame_valid : one-cycle pulse when digits updates
//   err         : one-cycle pulse on a frame error
//   err_cnt     : saturating count of err pulses
// -----------------------------------------------------------------------------
interface seg7_scan_decoder_if #(
    parameter int ERR_CNT_W = 8
);
    logic [3:0]           dig_sel;
    logic [6:0]           seg_in;
    logic [15:0]          digits;
    logic                 frame_valid;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output dig_sel, seg_in,
        input  digits, frame_valid, err, err_cnt
    );

    modport slave (
        input  dig_sel, seg_in,
        output digits, frame_valid, err, err_cnt
    );
endinterface

// File: rtl/seg7_to_bcd.sv
// -----------------------------------------------------------------------------
// seg7_to_bcd
// Combinational inverse of the 7-segment encoder table.
//   seg    : segment pattern {a..g}
//   valid  : pattern is one of the ten digit glyphs
//   nibble : decoded BCD digit (0 when invalid)
// -----------------------------------------------------------------------------
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned; otherwise synthesis infers a latch.
        valid  = 1'b1;
        nibble = 4'd0;
        case (seg)
            SEG7_0:  nibble = 4'd0;
            SEG7_1:  nibble = 4'd1;
            SEG7_2:  nibble = 4'd2;
            SEG7_3:  nibble = 4'd3;
            SEG7_4:  nibble = 4'd4;
            SEG7_5:  nibble = 4'd5;
            SEG7_6:  nibble = 4'd6;
            SEG7_7:  nibble = 4'd7;
            SEG7_8:  nibble = 4'd8;
            SEG7_9:  nibble = 4'd9;
            default: valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Monitors a multiplexed 4-digit 7-segment scan, filters each dwell for
// stability, decodes it back to BCD and assembles left-to-right frames.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seg7_scan_decoder_if.slave (dig_sel/seg_in in; digits,
//           frame_valid, err, err_cnt out)
// Parameters:
//   STABLE_CYCLES : edges a select/segment pair must hold before capture (2..255)
//   ERR_CNT_W     : width of the saturating error counter
// Configuration macro SEG7DEC_SYNC_EN: when defined, dig_sel and seg_in pass
// through a 2-flop synchronizer first (all latencies +2 edges); otherwise the
// inputs must already be synchronous to clk.
// -----------------------------------------------------------------------------
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_decoder_if.slave bus
);

    // Counter holds "matching edges after the first"; capture lands on the
    // edge where the pair has been seen STABLE_CYCLES times in a row.
    localparam logic [7:0] CAP_AT = 8'(STABLE_CYCLES - 2);

    logic [10:0] pair_in;

`ifdef SEG7DEC_SYNC_EN
    logic [10:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.dig_sel, bus.seg_in};
            sync2_q <= sync1_q;
        end
    end

    assign pair_in = sync2_q;
`else
    assign pair_in = {bus.dig_sel, bus.seg_in};
`endif

    // ---------------- stability filter ----------------
    logic [10:0] pair_q;
    logic [7:0]  stab_cnt_q;
    logic        done_q;
    logic        cap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q     <= '0;
            stab_cnt_q <= '0;
            done_q     <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge value of pair_q/stab_cnt_q regardless of order.
            pair_q <= pair_in;
            cap_q  <= 1'b0;
            if (pair_in != pair_q) begin
                stab_cnt_q <= '0;
                done_q     <= 1'b0;
            end else begin
                if (stab_cnt_q != 8'hFF) stab_cnt_q <= stab_cnt_q + 8'd1;
                // done_q keeps a long-held pair from being captured twice
                if (!done_q && stab_cnt_q == CAP_AT) begin
                    cap_q  <= 1'b1;
                    done_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- decode ----------------
    logic [3:0] sel;
    logic       dec_valid;
    logic [3:0] dec_nib;
    logic       one_hot;

    assign sel     = pair_q[10:7];
    assign one_hot = (sel == DSEL_D3) || (sel == DSEL_D2) ||
                     (sel == DSEL_D1) || (sel == DSEL_D0);

    seg7_to_bcd u_to_bcd (
        .seg    (pair_q[6:0]),
        .valid  (dec_valid),
        .nibble (dec_nib)
    );

    // ---------------- frame FSM ----------------
    state_t               state_q, state_d;
    logic [15:0]          frame_q, frame_d;
    logic [15:0]          digits_q, digits_d;
    logic                 fv_q, fv_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                 fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= HUNT;
            frame_q   <= '0;
            digits_q  <= '0;
            fv_q      <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            frame_q   <= frame_d;
            digits_q  <= digits_d;
            fv_q      <= fv_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        digits_d  = digits_q;
        fv_d      = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        fault     = 1'b0;

        // Blank-gap captures fall straight through with no effect.
        if (cap_q && sel != DSEL_BLANK) begin
            if (!one_hot || !dec_valid) begin
                fault = 1'b1;
            end else if (state_q == HUNT) begin
                // Non-D3 digits in HUNT are mid-frame lock-on: ignored.
                if (sel == DSEL_D3) begin
                    frame_d[15:12] = dec_nib;
                    state_d        = EXP_D2;
                end
            end else if (sel == expected_sel(state_q)) begin
                case (state_q)
                    EXP_D2: begin
                        frame_d[11:8] = dec_nib;
                        state_d       = EXP_D1;
                    end
                    EXP_D1: begin
                        frame_d[7:4] = dec_nib;
                        state_d      = EXP_D0;
                    end
                    EXP_D0: begin
                        digits_d = {frame_q[15:4], dec_nib};
                        fv_d     = 1'b1;
                        state_d  = HUNT;
                    end
                    default: state_d = HUNT;
                endcase
            end else begin
                fault = 1'b1;
            end

            if (fault) begin
                err_d = 1'b1;
                if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
                // A good D3 that broke the old frame opens the next one.
                if (sel == DSEL_D3 && dec_valid) begin
                    frame_d[15:12] = dec_nib;
                    state_d        = EXP_D2;
                end else begin
                    state_d = HUNT;
                end
            end
        end
    end

    assign bus.digits      = digits_q;
    assign bus.frame_valid = fv_q;
    assign bus.err         = err_q;
    assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed bench for seg7_scan_decoder (STABLE_CYCLES=4, ERR_CNT_W=8).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PBAD = 7'b0000001;

    localparam logic [3:0] S3 = 4'b1000;
    localparam logic [3:0] S2 = 4'b0100;
    localparam logic [3:0] S1 = 4'b0010;
    localparam logic [3:0] S0 = 4'b0001;
    localparam logic [3:0] SB = 4'b0000;

    localparam int DWELL = 6;

    logic clk;
    logic rst_n;

    seg7_scan_decoder_if #(.ERR_CNT_W(8)) bus ();

    seg7_scan_decoder #(
        .STABLE_CYCLES (4),
        .ERR_CNT_W     (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int fv_seen   = 0;
    int err_seen  = 0;
    int both_seen = 0;

    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) fv_seen++;
        if (bus.err === 1'b1) err_seen++;
        if (bus.frame_valid === 1'b1 && bus.err === 1'b1) both_seen++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic dwell(input logic [3:0] s, input logic [6:0] g, input int n);
        bus.dig_sel = s;
        bus.seg_in  = g;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame4(input logic [6:0] d3, input logic [6:0] d2,
                          input logic [6:0] d1, input logic [6:0] d0);
        dwell(S3, d3, DWELL);
        dwell(S2, d2, DWELL);
        dwell(S1, d1, DWELL);
        dwell(S0, d0, DWELL);
        dwell(SB, 7'b0, DWELL);
    endtask

    int fv0, err0;

    initial begin
        rst_n       = 1'b0;
        bus.dig_sel = SB;
        bus.seg_in  = 7'b0;
        repeat (3) @(negedge clk);

        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_fv", 32'(bus.frame_valid), 32'h0);
        check("rst_err", 32'(bus.err), 32'h0);
        check("rst_err_cnt", 32'(bus.err_cnt), 32'h0);
        rst_n = 1'b1;
        dwell(SB, 7'b0, DWELL);

        // Clean frame 1,7,7,8
        fv0 = fv_seen; err0 = err_seen;
        frame4(P1, P7, P7, P8);
        check("t1_fv_count", 32'(fv_seen - fv0), 32'd1);
        check("t1_err_count", 32'(err_seen - err0), 32'd0);
        check("t1_digits", 32'(bus.digits), 32'h1778);

        // Same frame with a 1-edge glitch select between D3 and D2
        fv0 = fv_seen; err0 = err_seen;
        dwell(S3, P1, DWELL);
        dwell(S1, P1, 1);
        dwell(S2, P7, DWELL);
        dwell(S1, P7, DWELL);
        dwell(S0, P8, DWELL);
        dwell(SB, 7'b0, DWELL);
        check("t2_fv_count", 32'(fv_seen - fv0), 32'd1);
        check("t2_err_count", 32'(err_seen - err0), 32'd0);
        check("t2_digits", 32'(bus.digits), 32'h1778);

        // Invalid pattern on D2
        fv0 = fv_seen; err0 = err_seen;
        dwell(S3, P1, DWELL);
        dwell(S2, PBAD, DWELL);
        dwell(SB, 7'b0, DWELL);
        check("t3_err_count", 32'(err_seen - err0), 32'd1);
        check("t3_err_cnt", 32'(bus.err_cnt), 32'd1);
        check("t3_fv_count", 32'(fv_seen - fv0), 32'd0);
        check("t3_digits_held", 32'(bus.digits), 32'h1778);
        fv0 = fv_seen;
        frame4(P2, P0, P2, P4);
        check("t3_recover_digits", 32'(bus.digits), 32'h2024);
        check("t3_recover_fv", 32'(fv_seen - fv0), 32'd1);

        // D3, D2, then D3 again: error that also opens a new frame
        fv0 = fv_seen; err0 = err_seen;
        dwell(S3, P5, DWELL);
        dwell(S2, P6, DWELL);
        dwell(S3, P5, DWELL);
        dwell(S2, P6, DWELL);
        dwell(S1, P7, DWELL);
        dwell(S0, P8, DWELL);
        dwell(SB, 7'b0, DWELL);
        check("t4_err_count", 32'(err_seen - err0), 32'd1);
        check("t4_err_cnt", 32'(bus.err_cnt), 32'd2);
        check("t4_fv_count", 32'(fv_seen - fv0), 32'd1);
        check("t4_digits", 32'(bus.digits), 32'h5678);

        // Reset, then start scanning mid-frame at D1
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("t5_digits_after_rst", 32'(bus.digits), 32'h0);
        fv0 = fv_seen; err0 = err_seen;
        dwell(S1, P3, DWELL);
        dwell(S0, P4, DWELL);
        check("t5_lockon_fv", 32'(fv_seen - fv0), 32'd0);
        check("t5_lockon_err", 32'(err_seen - err0), 32'd0);
        frame4(P9, P1, P2, P3);
        check("t5_full_fv", 32'(fv_seen - fv0), 32'd1);
        check("t5_full_err", 32'(err_seen - err0), 32'd0);
        check("t5_digits", 32'(bus.digits), 32'h9123);

        // 300 out-of-order errors: repeated D3 while expecting D2
        err0 = err_seen;
        for (int i = 0; i < 301; i++) begin
            dwell(S3, (i % 2 == 0) ? P1 : P2, DWELL);
        end
        dwell(SB, 7'b0, DWELL);
        check("t6_err_count", 32'(err_seen - err0), 32'd300);
        check("t6_err_cnt_sat", 32'(bus.err_cnt), 32'd255);

        // Asynchronous reset mid-frame
        dwell(S3, P4, DWELL);
        dwell(S2, P3, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_digits", 32'(bus.digits), 32'h0);
        check("t6_async_err_cnt", 32'(bus.err_cnt), 32'h0);
        check("t6_async_fv", 32'(bus.frame_valid), 32'h0);
        check("t6_async_err", 32'(bus.err), 32'h0);
        @(negedge clk);
        bus.dig_sel = SB;
        bus.seg_in  = 7'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dwell(SB, 7'b0, DWELL);
        fv0 = fv_seen; err0 = err_seen;
        frame4(P4, P3, P2, P1);
        check("t7_digits", 32'(bus.digits), 32'h4321);
        check("t7_fv_count", 32'(fv_seen - fv0), 32'd1);
        check("t7_err_cnt", 32'(bus.err_cnt), 32'd0);

        check("fv_err_exclusive", 32'(both_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_decoder.md
# seg7_scan_decoder

Decoder for the team's multiplexed 4-digit 7-segment scan interface. It samples the one-hot digit-select and segment lines from a scanning display driver and filters each dwell for stability. It decodes each segment pattern back to BCD and assembles a full left-to-right frame. It is used as a loop-back checker and monitor behind the display driver, and reports frame errors.

## Interface
- STABLE_CYCLES, 4: consecutive rising edges a select/segment pair must be identical before capture (range 2..255)
- ERR_CNT_W, 8: width of saturating error counter
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- DIG_SEL  in  4  one-hot digit select; 4'b1000 = leftmost digit (D3), 4'b0001 = rightmost (D0); 4'b0000 = blank gap
- SEG_IN  in  7  segments {a,b,c,d,e,f,g}, a = bit 6, active-high
- DIGITS  out  16  last good frame, {D3,D2,D1,D0} BCD nibbles
- FRAME_VALID  out  1  one-cycle pulse when DIGITS updates
- ERR  out  1  one-cycle pulse on frame error
- ERR_CNT  out  ERR_CNT_W  saturating count of ERR pulses

## Operation
- Reset values: DIGITS=16'h0000, FRAME_VALID=0, ERR=0, ERR_CNT=0, state HUNT, stability counter 0, capture-done flag 0.
- Stability filter: {DIG_SEL,SEG_IN} is registered each edge. Any change clears the counter and capture-done flag. The pair is "captured" once, on the edge where it has been seen on STABLE_CYCLES consecutive edges. A held pair is never re-captured.
- Captures with DIG_SEL=0000 are ignored (blank gap). They do not change state.
- Decode table (pattern -> digit):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9
  - Any other pattern is invalid.
- States: HUNT (expect D3), EXP_D2, EXP_D1, EXP_D0. On a valid capture of the expected select, store the nibble and advance. A D0 capture in EXP_D0 commits the frame to DIGITS, pulses FRAME_VALID and returns to HUNT.
- Error conditions, judged only on captures, never on glitches:
  - non-one-hot nonzero select
  - invalid pattern
  - select other than expected while not in HUNT
- On error: ERR pulses; ERR_CNT increments, saturating at all-ones; the partial frame is discarded and DIGITS is unchanged.
- Error restart rule: if the erroring capture is a valid D3, it starts a new frame and the next state is EXP_D2. Otherwise the next state is HUNT.
- In HUNT, a capture of a non-D3 one-hot select with a valid pattern is silently ignored and is not an error (mid-frame lock-on).
- An invalid pattern with select D3 while in HUNT is an error.
- FRAME_VALID and ERR are never high in the same cycle.
- Reset asserted mid-frame: all state clears immediately and the next frame starts from HUNT.

## Timing
- The pair is presented before edge e1 and held. Capture decision occurs at edge e(STABLE_CYCLES).
- FRAME_VALID/ERR/DIGITS/ERR_CNT are registered and visible after edge e(STABLE_CYCLES+1).
- A dwell shorter than STABLE_CYCLES edges is never captured.
- Back-to-back dwells with no blank gap are legal.
- Throughput: one frame per 4·STABLE_CYCLES edges minimum.

## Configuration
- SEG7DEC_SYNC_EN defined: DIG_SEL and SEG_IN each pass through a 2-flop synchronizer, reset to 0, before the filter. All latencies grow by 2 edges.
- Not defined: inputs feed the filter register directly. The inputs must be synchronous to CLK.

## Structure
- Package seg7_pkg holds:
  - segment pattern constants SEG7_0..SEG7_9
  - select constants DSEL_D3..DSEL_D0 and DSEL_BLANK
  - the state enum
- Sub-module seg7_to_bcd: combinational pattern -> {valid, nibble[3:0]}. This is the exact inverse of the encoder table.

## Test plan
- Scan 1,7,7,8 on D3..D0, 6 edges each, STABLE_CYCLES=4 -> single FRAME_VALID; DIGITS=16'h1778; ERR=0.
- Same frame with 1-edge glitch select 0010 between D3 and D2 -> no ERR; DIGITS=16'h1778.
- D3=1, D2=pattern 0000001 -> ERR pulse; ERR_CNT=1; DIGITS unchanged; following clean 2,0,2,4 frame -> DIGITS=16'h2024.
- D3, D2, then D3 again (digit 5) -> ERR; new frame starts; then D2=6, D1=7, D0=8 -> DIGITS=16'h5678.
- Start scanning at D1 after reset -> no ERR; first FRAME_VALID only after a full D3..D0 pass.
- 300 consecutive out-of-order errors -> ERR_CNT saturates at 255; RST_N low mid-frame clears all outputs to 0 asynchronously.
